// File: rtl/pass_launcher.sv
// Pass sequencer in front of the PE-array controller: latches a 9-word descriptor,
// optionally replays the XID/YID tables, then runs one start/done handshake and reports cycles.
module pass_launcher #(
  parameter int unsigned NUMS_PE_ROW = 6,
  parameter int unsigned NUMS_PE_COL = 8,
  parameter int unsigned XID_BITS    = 4,
  parameter int unsigned YID_BITS    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [31:0]         cfg_data,
  output logic [31:0]         op_config,
  output logic [31:0]         mapping_param,
  output logic [31:0]         shape_param1,
  output logic [31:0]         shape_param2,
  output logic [31:0]         filter_baseaddr,
  output logic [31:0]         ifmap_baseaddr,
  output logic [31:0]         bias_baseaddr,
  output logic [31:0]         opsum_baseaddr,
  output logic                bias_ipsum_sel,
  output logic                ctrl_ID_wen,
  output logic [2:0]          ctrl_ID_wsel,
  output logic [5:0]          ctrl_ID_widx,
  output logic [XID_BITS-1:0] ctrl_ID_wdata,
  input  logic                done,
  output logic                busy,
  output logic                pass_done,
  output logic [31:0]         run_cycles
);

  localparam int unsigned XID_ENTRIES = NUMS_PE_ROW * NUMS_PE_COL;
  localparam int unsigned ID_WORD_W   = (XID_BITS >= YID_BITS) ? XID_BITS : YID_BITS;
  localparam int unsigned HDR_LAST    = 8;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_ID    = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_REL   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic [3:0]           word_cnt;
  logic [2:0]           wsel_cnt;
  logic [5:0]           idx_cnt;
  logic [31:0]          run_cnt;
  logic                 final_q;
  logic [ID_WORD_W-1:0] id_word_c;

  logic hs_c;
  logic hdr_hs_c;
  logic id_hs_c;
  logic hdr_last_c;
  logic load_ids_c;
  logic tbl_last_c;
  logic id_last_c;
  logic final_hs_c;

  assign hs_c       = cfg_valid & cfg_ready;
  assign hdr_hs_c   = hs_c && (state == S_HDR);
  assign id_hs_c    = hs_c && (state == S_ID);
  assign hdr_last_c = hdr_hs_c && (word_cnt == 4'(HDR_LAST));
  assign load_ids_c = cfg_data[1];
  assign tbl_last_c = wsel_cnt[2] ? (idx_cnt == 6'(NUMS_PE_ROW - 1))
                                  : (idx_cnt == 6'(XID_ENTRIES - 1));
  assign id_last_c  = id_hs_c && (wsel_cnt == 3'd7) && tbl_last_c;
  // The final descriptor word closes the input one cycle before S_START so the last ID write lands first.
  assign final_hs_c = (hdr_last_c && !load_ids_c) || id_last_c;
  assign id_word_c  = cfg_data[ID_WORD_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_HDR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_HDR: begin
        if (final_q) begin
          next_state = S_START;
        end else if (hdr_last_c && load_ids_c) begin
          next_state = S_ID;
        end
      end
      S_ID: begin
        if (final_q) begin
          next_state = S_START;
        end
      end
      S_START: next_state = S_RUN;
      S_RUN: begin
        if (done) begin
          next_state = S_REL;
        end
      end
      S_REL: begin
        if (!done) begin
          next_state = S_FIN;
        end
      end
      S_FIN:   next_state = S_HDR;
      default: next_state = S_HDR;
    endcase
  end

  // Handshake, status and start-bit registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready    <= 1'b1;
      busy         <= 1'b0;
      pass_done    <= 1'b0;
      final_q      <= 1'b0;
      op_config[0] <= 1'b0;
    end else begin
      cfg_ready    <= ((next_state == S_HDR) || (next_state == S_ID)) && !final_hs_c;
      busy         <= (next_state != S_HDR);
      pass_done    <= (next_state == S_FIN);
      final_q      <= final_hs_c;
      op_config[0] <= (next_state == S_RUN);
    end
  end

  // Descriptor header latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt          <= '0;
      op_config[31:1]   <= '0;
      mapping_param     <= '0;
      shape_param1      <= '0;
      shape_param2      <= '0;
      filter_baseaddr   <= '0;
      ifmap_baseaddr    <= '0;
      bias_baseaddr     <= '0;
      opsum_baseaddr    <= '0;
      bias_ipsum_sel    <= 1'b0;
    end else if (hdr_hs_c) begin
      word_cnt <= hdr_last_c ? 4'd0 : word_cnt + 4'd1;
      case (word_cnt)
        4'd0:    op_config[31:1] <= cfg_data[31:1];
        4'd1:    mapping_param   <= cfg_data;
        4'd2:    shape_param1    <= cfg_data;
        4'd3:    shape_param2    <= cfg_data;
        4'd4:    filter_baseaddr <= cfg_data;
        4'd5:    ifmap_baseaddr  <= cfg_data;
        4'd6:    bias_baseaddr   <= cfg_data;
        4'd7:    opsum_baseaddr  <= cfg_data;
        default: bias_ipsum_sel  <= cfg_data[0];
      endcase
    end
  end

  // ID table replay: one registered write per accepted word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wsel_cnt      <= '0;
      idx_cnt       <= '0;
      ctrl_ID_wen   <= 1'b0;
      ctrl_ID_wsel  <= '0;
      ctrl_ID_widx  <= '0;
      ctrl_ID_wdata <= '0;
    end else begin
      ctrl_ID_wen <= id_hs_c;
      if (id_hs_c) begin
        ctrl_ID_wsel  <= wsel_cnt;
        ctrl_ID_widx  <= idx_cnt;
        ctrl_ID_wdata <= id_word_c[XID_BITS-1:0];
        if (tbl_last_c) begin
          idx_cnt  <= '0;
          wsel_cnt <= wsel_cnt + 3'd1;
        end else begin
          idx_cnt  <= idx_cnt + 6'd1;
        end
      end
    end
  end

  // Saturating run counter; result published together with pass_done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt    <= '0;
      run_cycles <= '0;
    end else begin
      if (state == S_START) begin
        run_cnt <= '0;
      end else if ((state == S_RUN) && (run_cnt != 32'hFFFF_FFFF)) begin
        run_cnt <= run_cnt + 32'd1;
      end
      if (next_state == S_FIN) begin
        run_cycles <= run_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pass_launcher.sv
// Scoreboard bench for pass_launcher: directed descriptors, ID replay ordering, done handshake timing.
module tb_pass_launcher;

  localparam int unsigned ROWS = 6;
  localparam int unsigned COLS = 8;
  localparam int unsigned XB   = 4;
  localparam int unsigned N_ID = 4 * ROWS * COLS + 4 * ROWS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [31:0]   cfg_data = '0;
  logic [31:0]   op_config, mapping_param, shape_param1, shape_param2;
  logic [31:0]   filter_baseaddr, ifmap_baseaddr, bias_baseaddr, opsum_baseaddr;
  logic          bias_ipsum_sel;
  logic          ctrl_ID_wen;
  logic [2:0]    ctrl_ID_wsel;
  logic [5:0]    ctrl_ID_widx;
  logic [XB-1:0] ctrl_ID_wdata;
  logic          done;
  logic          busy, pass_done;
  logic [31:0]   run_cycles;

  logic       done_mode = 1'b0;
  logic       done_man = 1'b0;
  logic [4:0] done_pipe = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int pd_cnt = 0;
  int wen_total = 0;
  int wen_run = 0;
  int wen_max = 0;
  logic pd_prev = 1'b0;
  logic [12:0] exp_w;
  logic [12:0] id_q[$];
  logic [12:0] wlog[$];
  logic [31:0] pd_q[$];

  pass_launcher #(.NUMS_PE_ROW(ROWS), .NUMS_PE_COL(COLS), .XID_BITS(XB), .YID_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .op_config(op_config), .mapping_param(mapping_param), .shape_param1(shape_param1),
    .shape_param2(shape_param2), .filter_baseaddr(filter_baseaddr), .ifmap_baseaddr(ifmap_baseaddr),
    .bias_baseaddr(bias_baseaddr), .opsum_baseaddr(opsum_baseaddr), .bias_ipsum_sel(bias_ipsum_sel),
    .ctrl_ID_wen(ctrl_ID_wen), .ctrl_ID_wsel(ctrl_ID_wsel), .ctrl_ID_widx(ctrl_ID_widx),
    .ctrl_ID_wdata(ctrl_ID_wdata), .done(done), .busy(busy), .pass_done(pass_done),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Controller model: done follows the start bit five cycles later, or is driven directly
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    done_pipe <= {done_pipe[3:0], op_config[0]};
  end
  assign done = done_mode ? done_man : done_pipe[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expected ID writes and pass results as the DUT presents them
  always @(negedge clk) begin
    if (ctrl_ID_wen) begin
      wen_total++;
      wen_run++;
      if (wen_run > wen_max) wen_max = wen_run;
      wlog.push_back({ctrl_ID_wsel, ctrl_ID_widx, ctrl_ID_wdata});
      if (id_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL id_unexpected: got wsel=%0d idx=%0d data=%0d with nothing expected",
                 ctrl_ID_wsel, ctrl_ID_widx, ctrl_ID_wdata);
      end else begin
        exp_w = id_q.pop_front();
        check("id_write", {19'd0, ctrl_ID_wsel, ctrl_ID_widx, ctrl_ID_wdata}, {19'd0, exp_w});
      end
    end else begin
      wen_run = 0;
    end
    if (pass_done) begin
      pd_cnt++;
      if (pd_prev) begin
        checks++;
        errors++;
        $display("FAIL pass_done_width: got 2+ cycle pulse, expected 1");
      end
      if (pd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pass_done_unexpected: got pulse with run_cycles=%0d, expected none", run_cycles);
      end else begin
        check("run_cycles", run_cycles, pd_q.pop_front());
      end
    end
    pd_prev = pass_done;
  end

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    bit rdy;
    int t = 0;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      cfg_valid = 1'b0;
      @(negedge clk);
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    do begin
      rdy = cfg_ready;
      @(negedge clk);
      t++;
    end while (!rdy && t < 100);
    hs_cyc    = cyc;
    cfg_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_word: got no handshake in 100 cycles, expected cfg_ready");
    end
  endtask

  task automatic send_hdr(input logic [31:0] opc, input logic [31:0] base, input logic [1:0] flags);
    for (int i = 0; i < 8; i++) send_word((i == 0) ? opc : base + 32'(i), 0);
    send_word({28'hF0F0F0C, 2'b00, flags}, 0);
  endtask

  task automatic send_ids(input int count, input int gap_pct);
    for (int n = 0; n < count; n++) send_word({28'hABCDEF1, 4'(n % 16)}, gap_pct);
  endtask

  task automatic push_ids(input int count);
    int n = 0;
    for (int ws = 0; ws < 8; ws++) begin
      int sz = (ws < 4) ? ROWS * COLS : ROWS;
      for (int ix = 0; ix < sz; ix++) begin
        if (n < count) id_q.push_back({3'(ws), 6'(ix), 4'(n % 16)});
        n++;
      end
    end
  endtask

  task automatic wait_op0(input logic lvl, output int at);
    int t = 0;
    while (op_config[0] !== lvl && t < 50) begin
      @(negedge clk);
      t++;
    end
    at = cyc;
    if (op_config[0] !== lvl) begin
      checks++;
      errors++;
      $display("FAIL wait_op0: got timeout, expected start bit %0b", lvl);
    end
  endtask

  task automatic wait_pd(input int prev);
    int t = 0;
    while (pd_cnt == prev && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (pd_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL wait_pd: got timeout, expected pass_done");
    end
  endtask

  initial begin
    int at, at2, p, bad;
    logic [12:0] log2[$];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_op_config", op_config, 32'h0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_run_cycles", run_cycles, 32'd0);
    check("rst_id_wen", 32'(ctrl_ID_wen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Header only, done = start delayed 5 cycles
    pd_q.push_back(32'd6);
    send_hdr(32'h0000_0009, 32'h1000_0000, 2'b01);
    check("t1_op_latched", op_config, 32'h0000_0008);
    check("t1_mapping", mapping_param, 32'h1000_0001);
    check("t1_opsum", opsum_baseaddr, 32'h1000_0007);
    check("t1_bias_sel", 32'(bias_ipsum_sel), 32'd1);
    p = hs_cyc;
    wait_op0(1'b1, at);
    check("t1_start_delay", 32'(at - p), 32'd2);
    check("t1_op_run", op_config, 32'h0000_0009);
    check("t1_busy_run", 32'(busy), 32'd1);
    wait_pd(0);
    repeat (3) @(negedge clk);
    check("t1_pd_count", 32'(pd_cnt), 32'd1);
    check("t1_ready_after", 32'(cfg_ready), 32'd1);

    // Full ID replay, cfg_valid held high
    wlog.delete();
    wen_max = 0;
    wen_total = 0;
    push_ids(N_ID);
    pd_q.push_back(32'd6);
    send_hdr(32'h0000_0100, 32'h2000_0000, 2'b10);
    send_ids(N_ID, 0);
    p = hs_cyc;
    wait_op0(1'b1, at);
    check("t2_start_delay", 32'(at - p), 32'd2);
    wait_pd(1);
    check("t2_wen_consec", 32'(wen_max), 32'd216);
    check("t2_wen_total", 32'(wen_total), 32'd216);
    check("t2_q_empty", 32'(id_q.size()), 32'd0);
    check("t2_first", {19'd0, wlog[0]}, {19'd0, 3'd0, 6'd0, 4'd0});
    check("t2_w48", {19'd0, wlog[48]}, {19'd0, 3'd1, 6'd0, 4'd0});
    check("t2_last", {19'd0, wlog[215]}, {19'd0, 3'd7, 6'd5, 4'd7});
    log2 = wlog;

    // Same replay with random valid gaps
    wlog.delete();
    wen_total = 0;
    push_ids(N_ID);
    pd_q.push_back(32'd6);
    send_hdr(32'h0000_0100, 32'h2000_0000, 2'b10);
    send_ids(N_ID, 50);
    p = hs_cyc;
    wait_op0(1'b1, at);
    check("t3_start_delay", 32'(at - p), 32'd2);
    wait_pd(2);
    check("t3_wen_total", 32'(wen_total), 32'd216);
    bad = 0;
    for (int i = 0; i < 216; i++) if (i >= wlog.size() || i >= log2.size() || wlog[i] !== log2[i]) bad++;
    check("t3_seq_diff", 32'(bad), 32'd0);

    // done held high 10 cycles after start drops
    done_mode = 1'b1;
    done_man  = 1'b0;
    pd_q.push_back(32'd4);
    send_hdr(32'h0000_0003, 32'h3000_0000, 2'b00);
    check("t4_bias_sel", 32'(bias_ipsum_sel), 32'd0);
    check("t4_op_latched", op_config, 32'h0000_0002);
    wait_op0(1'b1, at);
    repeat (3) @(negedge clk);
    done_man = 1'b1;
    wait_op0(1'b0, at2);
    check("t4_run_len", 32'(at2 - at), 32'd4);
    bad = 0;
    p = pd_cnt;
    for (int i = 0; i < 10; i++) begin
      if (pass_done || cfg_ready || !busy) bad++;
      @(negedge clk);
    end
    check("t4_rel_hold", 32'(bad), 32'd0);
    check("t4_no_pd_yet", 32'(pd_cnt), 32'(p));
    done_man = 1'b0;
    wait_pd(p);
    @(negedge clk);
    check("t4_ready_after", 32'(cfg_ready), 32'd1);

    // Spurious done while idle, then done already high at S_RUN entry
    done_man = 1'b1;
    p = pd_cnt;
    repeat (6) @(negedge clk);
    check("t6_no_pd", 32'(pd_cnt), 32'(p));
    check("t6_run_cycles", run_cycles, 32'd4);
    check("t6_busy", 32'(busy), 32'd0);
    pd_q.push_back(32'd1);
    send_hdr(32'h0000_0011, 32'h4000_0000, 2'b00);
    wait_op0(1'b1, at);
    wait_op0(1'b0, at2);
    check("t6_run_len", 32'(at2 - at), 32'd1);
    done_man = 1'b0;
    wait_pd(p);

    // Reset pulse after ID word 100
    wlog.delete();
    wen_total = 0;
    push_ids(100);
    send_hdr(32'h0000_0021, 32'h5000_0000, 2'b10);
    send_ids(100, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_op_config", op_config, 32'h0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(cfg_ready), 32'd1);
    check("t5_run_cycles", run_cycles, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_wen_total", 32'(wen_total), 32'd100);
    check("t5_q_empty", 32'(id_q.size()), 32'd0);
    done_mode = 1'b0;
    pd_q.push_back(32'd6);
    p = pd_cnt;
    send_hdr(32'h0000_0005, 32'h7000_0000, 2'b01);
    check("t5_op_latched", op_config, 32'h0000_0004);
    check("t5_mapping", mapping_param, 32'h7000_0001);
    check("t5_opsum", opsum_baseaddr, 32'h7000_0007);
    wait_op0(1'b1, at);
    wait_pd(p);
    repeat (3) @(negedge clk);
    check("end_pd_q_empty", 32'(pd_q.size()), 32'd0);
    check("end_id_q_empty", 32'(id_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
